// File: rtl/ddr_cmd_sched.sv
// DDR SDRAM command issuer: spacing timer, per-bank open tracking, negedge pin launch.
// Optional: define DDR_AUTO_PRECHARGE_EN to turn READ/WRITE into auto-precharge accesses.
module ddr_cmd_sched #(
    parameter int ROW_W   = 13,
    parameter int COL_W   = 10,
    parameter int BA_W    = 2,
    parameter int T_RCD   = 2,
    parameter int T_RP    = 2,
    parameter int T_RFC   = 10,
    parameter int T_MRD   = 2,
    parameter int T_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cke_en,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [BA_W+ROW_W+COL_W-1:0]   cmd_addr,
    output logic                          cmd_err,
    output logic [2**BA_W-1:0]            bank_open,
    output logic                          cke,
    output logic                          csn,
    output logic                          rasn,
    output logic                          casn,
    output logic                          wen,
    output logic [ROW_W-1:0]              ddr_addr,
    output logic [BA_W-1:0]               ddr_ba
);

    localparam int NBANK = 2**BA_W;

`ifdef DDR_AUTO_PRECHARGE_EN
    localparam int T_RW     = T_BURST + T_RP;
    localparam bit AUTO_PRE = 1'b1;
`else
    localparam int T_RW     = T_BURST;
    localparam bit AUTO_PRE = 1'b0;
`endif

    localparam int T_M1  = (T_RCD > T_RP)  ? T_RCD : T_RP;
    localparam int T_M2  = (T_M1 > T_RFC)  ? T_M1  : T_RFC;
    localparam int T_M3  = (T_M2 > T_MRD)  ? T_M2  : T_MRD;
    localparam int T_MAX = (T_M3 > T_RW)   ? T_M3  : T_RW;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] LD_RCD = TW'(T_RCD - 1);
    localparam logic [TW-1:0] LD_RP  = TW'(T_RP - 1);
    localparam logic [TW-1:0] LD_RFC = TW'(T_RFC - 1);
    localparam logic [TW-1:0] LD_MRD = TW'(T_MRD - 1);
    localparam logic [TW-1:0] LD_RW  = TW'(T_RW - 1);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ACT  = 3'd1,
        OP_RD   = 3'd2,
        OP_WR   = 3'd3,
        OP_PRE  = 3'd4,
        OP_PREA = 3'd5,
        OP_REF  = 3'd6,
        OP_LMR  = 3'd7
    } op_e;

    // {csn, rasn, casn, wen}
    typedef enum logic [3:0] {
        ENC_DESEL = 4'b1111,
        ENC_NOP   = 4'b0111,
        ENC_ACT   = 4'b0011,
        ENC_RD    = 4'b0101,
        ENC_WR    = 4'b0100,
        ENC_PRE   = 4'b0010,
        ENC_REF   = 4'b0001,
        ENC_LMR   = 4'b0000
    } enc_e;

    op_e              op;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [BA_W-1:0]  bank_sel;
    logic [ROW_W-1:0] col_addr;

    enc_e             cmd_q;
    logic [ROW_W-1:0] addr_q;
    logic [BA_W-1:0]  ba_q;
    logic             cke_q;
    logic [TW-1:0]    timer;

    logic             accept;
    logic             legal;
    logic             load_en;
    logic [TW-1:0]    load_val;
    enc_e             enc_n;
    logic [ROW_W-1:0] addr_n;
    logic [BA_W-1:0]  ba_n;
    logic [NBANK-1:0] open_n;

    assign op        = op_e'(cmd_op);
    assign col       = cmd_addr[COL_W-1:0];
    assign row       = cmd_addr[COL_W +: ROW_W];
    assign bank_sel  = cmd_addr[COL_W+ROW_W +: BA_W];
    assign cmd_ready = (timer == '0) && cke_en && cke;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        col_addr              = '0;
        col_addr[COL_W-1:0]   = col;
        col_addr[10]          = AUTO_PRE;
    end

    always_comb begin
        legal    = 1'b1;
        load_en  = 1'b0;
        load_val = '0;
        enc_n    = ENC_NOP;
        addr_n   = addr_q;
        ba_n     = ba_q;
        open_n   = bank_open;
        case (op)
            OP_ACT: begin
                if (bank_open[bank_sel]) begin
                    legal = 1'b0;
                end else begin
                    enc_n            = ENC_ACT;
                    addr_n           = row;
                    ba_n             = bank_sel;
                    open_n[bank_sel] = 1'b1;
                    load_en          = 1'b1;
                    load_val         = LD_RCD;
                end
            end
            OP_RD, OP_WR: begin
                if (!bank_open[bank_sel]) begin
                    legal = 1'b0;
                end else begin
                    if (op == OP_RD) enc_n = ENC_RD;
                    else             enc_n = ENC_WR;
                    addr_n   = col_addr;
                    ba_n     = bank_sel;
                    if (AUTO_PRE) open_n[bank_sel] = 1'b0;
                    load_en  = 1'b1;
                    load_val = LD_RW;
                end
            end
            OP_PRE: begin
                enc_n            = ENC_PRE;
                addr_n[10]       = 1'b0;
                ba_n             = bank_sel;
                open_n[bank_sel] = 1'b0;
                load_en          = 1'b1;
                load_val         = LD_RP;
            end
            OP_PREA: begin
                enc_n      = ENC_PRE;
                addr_n[10] = 1'b1;
                open_n     = '0;
                load_en    = 1'b1;
                load_val   = LD_RP;
            end
            OP_REF: begin
                if (|bank_open) begin
                    legal = 1'b0;
                end else begin
                    enc_n    = ENC_REF;
                    load_en  = 1'b1;
                    load_val = LD_RFC;
                end
            end
            OP_LMR: begin
                if (|bank_open) begin
                    legal = 1'b0;
                end else begin
                    enc_n    = ENC_LMR;
                    addr_n   = cmd_addr[ROW_W-1:0];
                    ba_n     = bank_sel;
                    load_en  = 1'b1;
                    load_val = LD_MRD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q     <= ENC_DESEL;
            addr_q    <= '0;
            ba_q      <= '0;
            bank_open <= '0;
            cmd_err   <= 1'b0;
            cke_q     <= 1'b0;
            timer     <= '0;
        end else begin
            cke_q   <= cke_en;
            cmd_err <= accept && !legal;
            if (accept && legal) begin
                cmd_q     <= enc_n;
                addr_q    <= addr_n;
                ba_q      <= ba_n;
                bank_open <= open_n;
            end else begin
                cmd_q <= ENC_NOP;
            end
            if (accept && legal && load_en) timer <= load_val;
            else if (timer != '0)           timer <= timer - TW'(1);
        end
    end

    // Half-cycle launch: pins sample the posedge registers on the falling edge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            {csn, rasn, casn, wen} <= ENC_DESEL;
            cke      <= 1'b0;
            ddr_addr <= '0;
            ddr_ba   <= '0;
        end else begin
            {csn, rasn, casn, wen} <= cmd_q;
            cke      <= cke_q;
            ddr_addr <= addr_q;
            ddr_ba   <= ba_q;
        end
    end

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Directed self-checking bench for ddr_cmd_sched (default parameters).
module tb_ddr_cmd_sched;

    localparam int AW = 25;
    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3,
                           PRE = 3'd4, PREA = 3'd5, REF = 3'd6, LMR = 3'd7;

`ifdef DDR_AUTO_PRECHARGE_EN
    localparam logic [12:0] RD_ADDR = 13'h0455;
    localparam logic [12:0] WR_ADDR = 13'h07FF;
    localparam logic [3:0]  OPEN1   = 4'b0000;
    localparam logic [3:0]  WR_OPEN = 4'b0000;
    localparam int          WR_GAP  = 6;
`else
    localparam logic [12:0] RD_ADDR = 13'h0055;
    localparam logic [12:0] WR_ADDR = 13'h03FF;
    localparam logic [3:0]  OPEN1   = 4'b0010;
    localparam logic [3:0]  WR_OPEN = 4'b0100;
    localparam int          WR_GAP  = 4;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cke_en = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic          cmd_err;
    logic [3:0]    bank_open;
    logic          cke, csn, rasn, casn, wen;
    logic [12:0]   ddr_addr;
    logic [1:0]    ddr_ba;
    logic [3:0]    pins;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    assign pins = {csn, rasn, casn, wen};

    ddr_cmd_sched dut (
        .clk(clk), .rst(rst), .cke_en(cke_en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_err(cmd_err), .bank_open(bank_open),
        .cke(cke), .csn(csn), .rasn(rasn), .casn(casn), .wen(wen),
        .ddr_addr(ddr_addr), .ddr_ba(ddr_ba)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [AW-1:0] mk(input logic [1:0] b, input logic [12:0] r, input logic [9:0] c);
        return {b, r, c};
    endfunction

    // Holds the request until accepted; returns the cycle count just after the accepting posedge.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] a, output int acc);
        int w = 0;
        cmd_op = op; cmd_addr = a; cmd_valid = 1'b1;
        while (!cmd_ready && w < 40) begin @(posedge clk); #1; w++; end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL issue_timeout op=%0d: cmd_ready=%b required 1", op, cmd_ready); end
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0; cmd_op = NOP;
    endtask

    task automatic test_reset;
        rst = 1'b0; cke_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (pins !== 4'b1111) begin n_bad++; $display("FAIL rst_pins: got %b required 1111", pins); end
        n_cmp++; if (cke !== 1'b0) begin n_bad++; $display("FAIL rst_cke: got %b required 0", cke); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b required 0", cmd_ready); end
        n_cmp++; if (bank_open !== 4'b0) begin n_bad++; $display("FAIL rst_open: got %b required 0000", bank_open); end
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b required 0", cmd_err); end
        n_cmp++; if ({ddr_addr, ddr_ba} !== 15'h0) begin n_bad++; $display("FAIL rst_addr: got %h/%h required 0/0", ddr_addr, ddr_ba); end
        @(negedge clk); #2; rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (cke !== 1'b0) begin n_bad++; $display("FAIL rel_cke_early: got %b required 0", cke); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rel_ready_early: got %b required 0", cmd_ready); end
        @(negedge clk); #1;
        n_cmp++; if (cke !== 1'b1) begin n_bad++; $display("FAIL rel_cke: got %b required 1", cke); end
        n_cmp++; if (pins !== 4'b0111) begin n_bad++; $display("FAIL rel_pins: got %b required 0111", pins); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready: got %b required 1", cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_act_read;
        int a0, a1;
        issue(ACT, mk(2'd1, 13'h0ABC, 10'h0), a0);
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL act_err: got %b required 0", cmd_err); end
        n_cmp++; if (bank_open !== 4'b0010) begin n_bad++; $display("FAIL act_open: got %b required 0010", bank_open); end
        @(negedge clk); #1;
        n_cmp++; if ({pins, ddr_ba, ddr_addr} !== {4'b0011, 2'd1, 13'h0ABC}) begin n_bad++; $display("FAIL act_pins: got %b/%h/%h required 0011/1/0abc", pins, ddr_ba, ddr_addr); end
        issue(RD, mk(2'd1, 13'h0, 10'h055), a1);
        n_cmp++; if (a1 - a0 !== 2) begin n_bad++; $display("FAIL rd_spacing: got %0d required 2", a1 - a0); end
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b required 0", cmd_err); end
        @(negedge clk); #1;
        n_cmp++; if ({pins, ddr_ba, ddr_addr} !== {4'b0101, 2'd1, RD_ADDR}) begin n_bad++; $display("FAIL rd_pins: got %b/%h/%h required 0101/1/%h", pins, ddr_ba, ddr_addr, RD_ADDR); end
        @(negedge clk); #1;
        n_cmp++; if (pins !== 4'b0111) begin n_bad++; $display("FAIL rd_then_nop: got %b required 0111", pins); end
    endtask

    task automatic test_rd_closed;
        int a;
        issue(RD, mk(2'd2, 13'h0, 10'h010), a);
        n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL closed_err: got %b required 1", cmd_err); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL closed_ready: got %b required 1", cmd_ready); end
        n_cmp++; if (bank_open !== OPEN1) begin n_bad++; $display("FAIL closed_open: got %b required %b", bank_open, OPEN1); end
        @(negedge clk); #1;
        n_cmp++; if ({pins, ddr_ba, ddr_addr} !== {4'b0111, 2'd1, RD_ADDR}) begin n_bad++; $display("FAIL closed_pins: got %b/%h/%h required 0111/1/%h", pins, ddr_ba, ddr_addr, RD_ADDR); end
        @(posedge clk); #1;
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL closed_err_len: got %b required 0", cmd_err); end
    endtask

    task automatic test_refresh;
        int a0, a1, cnt;
        issue(ACT, mk(2'd0, 13'h0011, 10'h0), a0);
        issue(ACT, mk(2'd3, 13'h1FFF, 10'h0), a0);
        n_cmp++; if (bank_open !== (OPEN1 | 4'b1001)) begin n_bad++; $display("FAIL two_open: got %b required %b", bank_open, OPEN1 | 4'b1001); end
        issue(REF, '0, a0);
        n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL ref_open_err: got %b required 1", cmd_err); end
        issue(PREA, '0, a0);
        n_cmp++; if (bank_open !== 4'b0) begin n_bad++; $display("FAIL prea_open: got %b required 0000", bank_open); end
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL prea_err: got %b required 0", cmd_err); end
        @(negedge clk); #1;
        n_cmp++; if ({pins, ddr_addr[10]} !== 5'b0010_1) begin n_bad++; $display("FAIL prea_pins: got %b a10=%b required 0010 a10=1", pins, ddr_addr[10]); end
        issue(REF, '0, a1);
        n_cmp++; if (a1 - a0 !== 2) begin n_bad++; $display("FAIL ref_spacing: got %0d required 2", a1 - a0); end
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL ref_err: got %b required 0", cmd_err); end
        @(negedge clk); #1;
        n_cmp++; if (pins !== 4'b0001) begin n_bad++; $display("FAIL ref_pins: got %b required 0001", pins); end
        cnt = 0;
        while (!cmd_ready && cnt < 20) begin cnt++; @(negedge clk); #1; end
        n_cmp++; if (cnt !== 9) begin n_bad++; $display("FAIL ref_block: got %0d required 9", cnt); end
    endtask

    task automatic test_auto_pre;
        int a0, a1, a2, a3;
        issue(ACT, mk(2'd2, 13'h0123, 10'h0), a0);
        issue(ACT, mk(2'd2, 13'h0456, 10'h0), a0);
        n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL act_open_err: got %b required 1", cmd_err); end
        n_cmp++; if (bank_open !== 4'b0100) begin n_bad++; $display("FAIL act_open_flags: got %b required 0100", bank_open); end
        issue(WR, mk(2'd2, 13'h0, 10'h3FF), a1);
        n_cmp++; if (bank_open !== WR_OPEN) begin n_bad++; $display("FAIL wr_open: got %b required %b", bank_open, WR_OPEN); end
        @(negedge clk); #1;
        n_cmp++; if ({pins, ddr_ba, ddr_addr} !== {4'b0100, 2'd2, WR_ADDR}) begin n_bad++; $display("FAIL wr_pins: got %b/%h/%h required 0100/2/%h", pins, ddr_ba, ddr_addr, WR_ADDR); end
        issue(NOP, '0, a2);
        n_cmp++; if (a2 - a1 !== WR_GAP) begin n_bad++; $display("FAIL wr_spacing: got %0d required %0d", a2 - a1, WR_GAP); end
        issue(NOP, '0, a3);
        n_cmp++; if (a3 - a2 !== 1) begin n_bad++; $display("FAIL nop_b2b: got %0d required 1", a3 - a2); end
    endtask

    task automatic test_pre_lmr;
        int a0, a1, a2;
        issue(PRE, mk(2'd2, 13'h0, 10'h0), a0);
        n_cmp++; if ({cmd_err, bank_open} !== 5'b0_0000) begin n_bad++; $display("FAIL pre_state: got err=%b open=%b required 0/0000", cmd_err, bank_open); end
        @(negedge clk); #1;
        n_cmp++; if ({pins, ddr_ba, ddr_addr[10]} !== {4'b0010, 2'd2, 1'b0}) begin n_bad++; $display("FAIL pre_pins: got %b/%h a10=%b required 0010/2 a10=0", pins, ddr_ba, ddr_addr[10]); end
        issue(PRE, mk(2'd2, 13'h0, 10'h0), a1);
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL pre_closed_err: got %b required 0", cmd_err); end
        n_cmp++; if (a1 - a0 !== 2) begin n_bad++; $display("FAIL pre_spacing: got %0d required 2", a1 - a0); end
        issue(LMR, mk(2'd1, 13'h0, 10'h123), a2);
        n_cmp++; if (a2 - a1 !== 2) begin n_bad++; $display("FAIL pre2_spacing: got %0d required 2", a2 - a1); end
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL lmr_err: got %b required 0", cmd_err); end
        @(negedge clk); #1;
        n_cmp++; if ({pins, ddr_ba, ddr_addr} !== {4'b0000, 2'd1, 13'h0123}) begin n_bad++; $display("FAIL lmr_pins: got %b/%h/%h required 0000/1/0123", pins, ddr_ba, ddr_addr); end
    endtask

    task automatic test_cke;
        int cnt;
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL cke_idle_ready: got %b required 1", cmd_ready); end
        cke_en = 1'b0; #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL cke_ready_drop: got %b required 0", cmd_ready); end
        @(posedge clk); #1;
        n_cmp++; if (cke !== 1'b1) begin n_bad++; $display("FAIL cke_hold: got %b required 1", cke); end
        @(negedge clk); #1;
        n_cmp++; if (cke !== 1'b0) begin n_bad++; $display("FAIL cke_fall: got %b required 0", cke); end
        cke_en = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL cke_ready_wait: got %b required 0", cmd_ready); end
        cnt = 0;
        while (!cmd_ready && cnt < 10) begin cnt++; @(negedge clk); #1; end
        n_cmp++; if ({cke, cmd_ready} !== 2'b11) begin n_bad++; $display("FAIL cke_recover: got cke=%b ready=%b required 1/1", cke, cmd_ready); end
    endtask

    task automatic test_reset_mid;
        int a;
        @(posedge clk); #1;
        issue(ACT, mk(2'd0, 13'h0777, 10'h0), a);
        #2; rst = 1'b0; #1;
        n_cmp++; if ({pins, cke, bank_open, cmd_ready} !== {4'b1111, 1'b0, 4'b0000, 1'b0}) begin n_bad++; $display("FAIL mid_reset: got pins=%b cke=%b open=%b ready=%b required 1111/0/0000/0", pins, cke, bank_open, cmd_ready); end
        n_cmp++; if ({ddr_addr, ddr_ba} !== 15'h0) begin n_bad++; $display("FAIL mid_reset_addr: got %h/%h required 0/0", ddr_addr, ddr_ba); end
    endtask

    initial begin
        test_reset();
        test_act_read();
        test_rd_closed();
        test_refresh();
        test_auto_pre();
        test_pre_lmr();
        test_cke();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_sched.md
# ddr_cmd_sched

Parametrised DDR SDRAM command issuer between the controller's command FSMs and the DDR pins. Accepts one abstract command per valid/ready handshake, enforces per-command minimum spacing with an internal timer, and tracks open/closed state per bank. It rejects illegal sequences, encodes the command onto {csn,rasn,casn,wen}/address/bank, and launches the pins on the falling clock edge.

## Interface
- ROW_W, 13, row address width; also the ddr_addr width (ROW_W ≥ 11)
- COL_W, 10, column address width (COL_W ≤ 10)
- BA_W, 2, bank address width; NBANK = 2**BA_W
- T_RCD, 2, ACTIVE-to-next-command spacing in cycles (≥1)
- T_RP, 2, PRECHARGE-to-next-command spacing (≥1)
- T_RFC, 10, AUTO_REFRESH-to-next-command spacing (≥1)
- T_MRD, 2, LOAD_MODE-to-next-command spacing (≥1)
- T_BURST, 4, READ/WRITE-to-next-command spacing (≥1)
- clk  in  1  clock; commands are registered on posedge and the pins are driven on negedge
- rst  in  1  asynchronous, active-low reset
- cke_en  in  1  requested CKE level
- cmd_valid  in  1  request present
- cmd_ready  out  1  request accepted when both cmd_valid and cmd_ready are high on a posedge
- cmd_op  in  3  0 NOP, 1 ACTIVE, 2 READ, 3 WRITE, 4 PRECHARGE, 5 PRECHARGE_ALL, 6 AUTO_REFRESH, 7 LOAD_MODE
- cmd_addr  in  BA_W+ROW_W+COL_W  {bank, row, col}
- cmd_err  out  1  one-cycle pulse: the accepted command was illegal and was dropped
- bank_open  out  NBANK  per-bank open flag
- cke, csn, rasn, casn, wen  out  1  DDR control pins
- ddr_addr  out  ROW_W  DDR address pins
- ddr_ba  out  BA_W  DDR bank pins

## Operation
- Encodings for {csn,rasn,casn,wen}:
  - DESELECT 1111, NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100
  - PRECHARGE 0010, AUTO_REFRESH 0001, LOAD_MODE 0000
- Behaviour per accepted command (bank_sel is the bank field of cmd_addr):
  - ACTIVE: ddr_addr = row, ddr_ba = bank_sel; sets bank_open[bank_sel].
  - READ/WRITE: ddr_addr = column, zero-extended; A10 is set per Configuration; ddr_ba = bank_sel.
  - PRECHARGE: A10 = 0; clears bank_open[bank_sel].
  - PRECHARGE_ALL: PRECHARGE encoding with A10 = 1; clears all bank_open flags.
  - AUTO_REFRESH: no address change.
  - LOAD_MODE: ddr_ba = bank_sel; ddr_addr = cmd_addr[ROW_W-1:0].
  - NOP: encodes NOP; timer not loaded.
- Illegal commands are accepted, but the command register gets NOP, the timer is not loaded, and cmd_err pulses:
  - READ/WRITE to a closed bank
  - ACTIVE to an open bank
  - AUTO_REFRESH or LOAD_MODE while any bank is open
- Spacing timer:
  - On a legal accept of op X, load T_X−1 (T_BURST for READ/WRITE).
  - Decrement each cycle while nonzero.
  - cmd_ready = (timer==0) && cke_en && cke (the registered pin value).
- Command register returns to NOP on every posedge without an accept; address/bank registers hold their last value.

## Timing
- Reset (async, rst low):
  - {csn,rasn,casn,wen} = 1111, cke = 0, ddr_addr = 0, ddr_ba = 0
  - bank_open = 0, cmd_err = 0, timer = 0
  - cmd_ready = 0 (since cke = 0)
- Reset mid-operation: all state is cleared immediately and bank tracking is lost. The controller must re-run init.
- Accept on posedge n: the internal register updates at posedge n, and the pins update at the negedge inside cycle n (half-cycle launch). Pins show NOP from the negedge in cycle n+1 unless another command is accepted.
- Spacing: after a legal accept of op X at posedge n, the earliest next accept is posedge n+T_X. With T_X = 1, back-to-back accepts are allowed.
- cke: cke_en is registered on posedge and driven on the following negedge. cmd_ready stays low until cke is high.
- cmd_err is asserted in cycle n+1 for exactly one cycle.
- Simultaneous PRECHARGE on an already-closed bank is legal (no error). The timer still loads T_RP−1.

## Configuration
- DDR_AUTO_PRECHARGE_EN defined:
  - READ/WRITE drive A10 = 1 and clear bank_open[bank_sel].
  - The timer loads T_BURST+T_RP−1.
- DDR_AUTO_PRECHARGE_EN undefined:
  - READ/WRITE drive A10 = 0; the bank stays open.
  - The timer loads T_BURST−1.

## Test plan
- Reset release with cke_en = 1:
  - pins stay 1111 while rst is low
  - cke = 1 after the first negedge; cmd_ready = 1 on the next posedge
- ACTIVE bank 1 row 0x0ABC, then READ col 0x055 (defaults):
  - READ is accepted exactly 2 cycles after ACTIVE
  - pins are 0011/ba = 1/addr = 0x0ABC, then 0101/ba = 1/addr = 0x055 (0x455 with the macro)
- READ to closed bank 2:
  - cmd_err pulses for 1 cycle; pins remain 0111; bank_open unchanged; cmd_ready stays 1
- Two banks open, then AUTO_REFRESH:
  - the AUTO_REFRESH is rejected with cmd_err
- Then PRECHARGE_ALL followed by AUTO_REFRESH:
  - PRECHARGE_ALL drives 0010 with addr[10] = 1; bank_open = 0
  - AUTO_REFRESH is accepted after 2 cycles
  - cmd_ready stays low for 9 cycles, then rises
- Macro on: WRITE to an open bank:
  - A10 = 1 and the bank flag clears
  - next command is blocked for 6 cycles (T_BURST+T_RP)
- Deassert cke_en mid-stream:
  - cmd_ready drops within 1 cycle and cke falls at the next negedge
